// File: rtl/uart_wb_bridge.sv
// uart_wb_bridge: uart2bus register file that launches single pipelined Wishbone transfers
module uart_wb_bridge #(
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 10
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] int_address,
    input  logic [7:0]  int_wr_data,
    input  logic        int_write,
    input  logic        int_read,
    input  logic        int_req,
    output logic        int_gnt,
    output logic [7:0]  int_rd_data,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_addr_o,
    output logic [31:0] wb_data_o,
    input  logic [31:0] wb_data_i,
    input  logic        wb_stall_i,
    input  logic        wb_ack_i
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_ACK} state_t;
    state_t state_q, state_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [7:0] ctrl_q, ctrl_d, rd_data_q, rd_data_d, rd_byte;
    logic done_q, done_d, to_q, to_d, ovr_q, ovr_d, gnt_q;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic in_map, busy, ack_done;
    logic [3:0] off;
    logic [4:0] sh;
    assign in_map = int_address[15:4] == 12'h000;
    assign off = int_address[3:0];
    assign sh = {off[1:0], 3'b000};
    assign busy = state_q != IDLE;
    assign ack_done = wb_ack_i && ((state_q == REQ && !wb_stall_i) || state_q == WAIT_ACK);
    always_comb begin
        rd_byte = 8'h00;
        if (in_map)
            case (off[3:2])
                2'd0: rd_byte = addr_q[sh +: 8];
                2'd1: rd_byte = wdata_q[sh +: 8];
                2'd2: rd_byte = off[1:0] == 2'd0 ? ctrl_q :
                                off[1:0] == 2'd1 ? {4'h0, ovr_q, to_q, done_q, busy} : 8'h00;
                default: rd_byte = rdata_q[sh +: 8];
            endcase
    end
    always_comb begin
        state_d = state_q;
        addr_d = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ctrl_d = ctrl_q;
        done_d = done_q;
        to_d = to_q;
        ovr_d = ovr_q;
        cnt_d = cnt_q;
        rd_data_d = int_read ? rd_byte : rd_data_q;
        if (int_read && in_map && off == 4'h9) begin
            done_d = 1'b0;
            to_d = 1'b0;
            ovr_d = 1'b0;
        end
        // ADDR/WDATA/CTRL writes; any of them while a transfer is running is an overrun
        if (int_write && in_map && off < 4'h9) begin
            if (busy) ovr_d = 1'b1;
            else if (off[3]) begin
                ctrl_d = int_wr_data;
                done_d = 1'b0;
                to_d = 1'b0;
                cnt_d = '0;
                state_d = REQ;
            end
            else if (off[2]) wdata_d[sh +: 8] = int_wr_data;
            else addr_d[sh +: 8] = int_wr_data;
        end
        if (ack_done) begin
            state_d = IDLE;
            done_d = 1'b1;
            if (!ctrl_q[1]) rdata_d = wb_data_i;
            if (ctrl_q[2]) addr_d = addr_q + 32'd4;
        end else if (busy) begin
            if (cnt_q == TO_W'(TIMEOUT - 1)) begin
                state_d = IDLE;
                to_d = 1'b1;
                done_d = 1'b0;
            end else begin
                cnt_d = cnt_q + TO_W'(1);
                if (state_q == REQ && !wb_stall_i) state_d = WAIT_ACK;
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ctrl_q <= '0;
            rd_data_q <= '0;
            done_q <= 1'b0;
            to_q <= 1'b0;
            ovr_q <= 1'b0;
            cnt_q <= '0;
            gnt_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ctrl_q <= ctrl_d;
            rd_data_q <= rd_data_d;
            done_q <= done_d;
            to_q <= to_d;
            ovr_q <= ovr_d;
            cnt_q <= cnt_d;
            gnt_q <= int_req;
        end
    end
    assign int_gnt = gnt_q;
    assign int_rd_data = rd_data_q;
    assign wb_cyc_o = busy;
    assign wb_stb_o = state_q == REQ;
    assign wb_we_o = ctrl_q[1];
    assign wb_sel_o = ctrl_q[7:4];
    assign wb_addr_o = addr_q;
    assign wb_data_o = wdata_q;
endmodule

// File: tb/tb_uart_wb_bridge.sv
// tb_uart_wb_bridge: randomized register/transfer scoreboard bench for uart_wb_bridge
module tb_uart_wb_bridge;
    localparam int TIMEOUT = 1024;
    logic clk = 1'b0;
    logic rst_i;
    logic [15:0] int_address;
    logic [7:0] int_wr_data, int_rd_data;
    logic int_write, int_read, int_req, int_gnt;
    logic wb_cyc_o, wb_stb_o, wb_we_o, wb_stall_i, wb_ack_i;
    logic [3:0] wb_sel_o;
    logic [31:0] wb_addr_o, wb_data_o, wb_data_i;
    always #5 clk = ~clk;
    uart_wb_bridge #(.TIMEOUT(TIMEOUT), .TO_W(10)) dut (
        .clk_i(clk), .rst_i(rst_i), .int_address(int_address), .int_wr_data(int_wr_data),
        .int_write(int_write), .int_read(int_read), .int_req(int_req), .int_gnt(int_gnt),
        .int_rd_data(int_rd_data), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_data_i(wb_data_i),
        .wb_stall_i(wb_stall_i), .wb_ack_i(wb_ack_i)
    );
    int checks = 0, errors = 0;
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    typedef struct packed {logic [31:0] a; logic [31:0] d; logic we; logic [3:0] sel;} xfer_t;
    xfer_t exp_x[$];
    logic [7:0] exp_rd[$];
    int exp_len[$];
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [7:0] m_ctrl;
    bit m_busy, m_done, m_to, m_ovr;
    function automatic void m_reset();
        m_addr = 0; m_wdata = 0; m_rdata = 0; m_ctrl = 0;
        m_busy = 0; m_done = 0; m_to = 0; m_ovr = 0;
    endfunction
    function automatic logic [7:0] m_read(logic [15:0] a);
        logic [7:0] v = 8'h00;
        int sh = 8 * int'(a[1:0]);
        if (a[15:4] == 12'h000) begin
            if (a[3:2] == 2'd0) v = 8'(m_addr >> sh);
            else if (a[3:2] == 2'd1) v = 8'(m_wdata >> sh);
            else if (a[3:2] == 2'd3) v = 8'(m_rdata >> sh);
            else if (a[3:0] == 4'h8) v = m_ctrl;
            else if (a[3:0] == 4'h9) begin
                v = {4'h0, m_ovr, m_to, m_done, m_busy};
                m_done = 0; m_to = 0; m_ovr = 0;
            end
        end
        return v;
    endfunction
    function automatic void m_write(logic [15:0] a, logic [7:0] d);
        int sh = 8 * int'(a[1:0]);
        logic [31:0] mask = 32'hFF << sh;
        if (a[15:4] != 12'h000 || a[3:0] > 4'h8) return;
        if (m_busy) m_ovr = 1;
        else if (a[3:0] == 4'h8) begin
            m_ctrl = d; m_done = 0; m_to = 0; m_busy = 1;
            exp_x.push_back({m_addr, m_wdata, d[1], d[7:4]});
        end
        else if (a[2]) m_wdata = (m_wdata & ~mask) | (32'(d) << sh);
        else m_addr = (m_addr & ~mask) | (32'(d) << sh);
    endfunction
    function automatic void m_complete(logic [31:0] rd);
        if (!m_busy) return;
        if (!m_ctrl[1]) m_rdata = rd;
        if (m_ctrl[2]) m_addr = m_addr + 32'd4;
        m_busy = 0; m_done = 1;
    endfunction
    function automatic void m_timeout();
        if (!m_busy) return;
        m_busy = 0; m_to = 1; m_done = 0;
    endfunction
    int s_stall = 0, s_dly = 0;
    logic [31:0] s_data = 0;
    bit skip_len = 0;
    initial begin
        wb_stall_i = 1'b1;
        wb_ack_i = 1'b0;
        wb_data_i = '0;
    end
    // Slave: stall s_stall edges, accept, then ack s_dly edges later (0 = on accept, <0 = never)
    always begin
        @(posedge clk); #1;
        if (wb_stb_o && !rst_i) begin
            exp_len.push_back(s_dly < 0 ? TIMEOUT : s_stall + 1 + (s_dly > 0 ? s_dly : 0));
            repeat (s_stall) begin @(posedge clk); #1; end
            wb_stall_i = 1'b0;
            wb_data_i = s_data;
            wb_ack_i = (s_dly == 0);
            @(posedge clk); #1;
            wb_stall_i = 1'b1;
            if (s_dly == 0) begin
                wb_ack_i = 1'b0;
                m_complete(s_data);
            end else if (s_dly > 0) begin
                repeat (s_dly - 1) begin @(posedge clk); #1; end
                wb_ack_i = 1'b1;
                @(posedge clk); #1;
                wb_ack_i = 1'b0;
                m_complete(s_data);
            end else begin
                repeat (TIMEOUT - s_stall - 1) begin @(posedge clk); #1; end
                m_timeout();
            end
        end
    end
    always @(negedge clk) begin
        if (!rst_i && wb_cyc_o && wb_stb_o && !wb_stall_i) begin
            if (exp_x.size() == 0) begin
                checks++; errors++;
                $display("FAIL wb_accept: got unexpected accept at addr %h expected none", wb_addr_o);
            end else begin
                xfer_t e;
                e = exp_x.pop_front();
                check("wb_addr", wb_addr_o, e.a);
                check("wb_data", wb_data_o, e.d);
                check("wb_we", 32'(wb_we_o), 32'(e.we));
                check("wb_sel", 32'(wb_sel_o), 32'(e.sel));
            end
        end
    end
    int cyc_len = 0;
    always @(negedge clk) begin
        if (wb_cyc_o) cyc_len++;
        else if (cyc_len > 0) begin
            if (skip_len) begin
                skip_len = 0;
                if (exp_len.size() > 0) void'(exp_len.pop_front());
            end else if (exp_len.size() == 0) begin
                checks++; errors++;
                $display("FAIL cyc_len: got %0d cycles expected no transfer", cyc_len);
            end else check("cyc_len", cyc_len, exp_len.pop_front());
            cyc_len = 0;
        end
    end
    always @(posedge clk) begin
        if (int_read) begin
            #1;
            if (exp_rd.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_data: got %h expected no read", int_rd_data);
            end else check("rd_data", 32'(int_rd_data), 32'(exp_rd.pop_front()));
        end
    end
    task automatic wr(logic [15:0] a, logic [7:0] d);
        int_address = a; int_wr_data = d; int_write = 1'b1;
        @(posedge clk); #1;
        int_write = 1'b0;
        m_write(a, d);
    endtask
    task automatic rd(logic [15:0] a);
        exp_rd.push_back(m_read(a));
        int_address = a; int_read = 1'b1;
        @(posedge clk); #1;
        int_read = 1'b0;
    endtask
    task automatic wr32(logic [15:0] base, logic [31:0] v);
        for (int i = 0; i < 4; i++) wr(base + 16'(i), 8'(v >> (8 * i)));
    endtask
    task automatic rd_range(int lo, int hi);
        for (int i = lo; i <= hi; i++) rd(16'(i));
    endtask
    task automatic start(logic [7:0] ctrl, int stall, int dly, logic [31:0] data);
        s_stall = stall; s_dly = dly; s_data = data;
        wr(16'h0008, ctrl);
    endtask
    task automatic wait_idle();
        int n = 0;
        while (m_busy && n < 3000) begin @(posedge clk); #1; n++; end
        if (m_busy) begin
            checks++; errors++;
            $display("FAIL wait_idle: got busy after %0d cycles expected idle", n);
            m_reset();
        end
        repeat (2) begin @(posedge clk); #1; end
    endtask
    task automatic cycles(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask
    initial begin
        rst_i = 1'b1; int_address = '0; int_wr_data = '0;
        int_write = 1'b0; int_read = 1'b0; int_req = 1'b0;
        m_reset();
        cycles(3);
        rst_i = 1'b0;
        check("rst_gnt", 32'(int_gnt), 0);
        check("rst_cyc", 32'(wb_cyc_o), 0);
        check("rst_stb", 32'(wb_stb_o), 0);
        check("rst_addr", wb_addr_o, 0);
        rd_range(0, 15);
        int_req = 1'b1;
        cycles(1);
        check("gnt_rise", 32'(int_gnt), 1);
        int_req = 1'b0;
        cycles(1);
        check("gnt_fall", 32'(int_gnt), 0);
        int_req = 1'b1;
        wr32(16'h0000, 32'h0000_0100);
        wr32(16'h0004, 32'hDEAD_BEEF);
        start(8'hF2, 3, 2, $urandom);
        wait_idle();
        rd(16'h0009); rd(16'h0009);
        wr32(16'h0000, 32'h0000_0100);
        start(8'hF4, 0, 0, 32'h1234_5678);
        wait_idle();
        rd_range(12, 15); rd_range(0, 3); rd(16'h0008); rd(16'h0009);
        wr32(16'h0000, 32'hFFFF_FFFC);
        start(8'h16, 1, 1, $urandom);
        wait_idle();
        rd_range(0, 3);
        wr(16'h0010, 8'hAA); wr(16'h1003, 8'h55);
        rd(16'h0010); rd(16'h1003); rd(16'h0003); rd(16'h000A); rd(16'h000B);
        start(8'hF0, 0, -1, 32'hCAFE_F00D);
        cycles(100);
        wr(16'h0008, 8'hF2);
        rd(16'h0009);
        wr(16'h0000, 8'h55);
        wait_idle();
        rd(16'h0009); rd(16'h0009); rd_range(0, 3); rd_range(12, 15); rd(16'h0008);
        start(8'h20, 0, 10, 32'h0BAD_0BAD);
        cycles(3);
        skip_len = 1;
        rst_i = 1'b1;
        cycles(1);
        m_reset();
        check("rst_mid_cyc", 32'(wb_cyc_o), 0);
        check("rst_mid_stb", 32'(wb_stb_o), 0);
        rst_i = 1'b0;
        cycles(15);
        rd_range(0, 15);
        for (int t = 0; t < 25; t++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC - 32'($urandom_range(0, 1) * 4) : $urandom;
            wr32(16'h0000, a);
            wr32(16'h0004, $urandom);
            start(8'($urandom), $urandom_range(0, 4), $urandom_range(0, 4), $urandom);
            wait_idle();
            rd(16'h0009); rd(16'h0009); rd(16'h0008);
            for (int k = 0; k < 6; k++)
                rd({($urandom_range(0, 3) == 0) ? 12'($urandom_range(1, 4095)) : 12'h000, 4'($urandom_range(0, 15))});
        end
        cycles(20);
        check("left_xfers", exp_x.size(), 0);
        check("left_reads", exp_rd.size(), 0);
        check("left_lens", exp_len.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_wb_bridge.md
Name: uart_wb_bridge

Overview:
- Wishbone (pipelined) master that sits between uart2bus_top's register-file interface and the sdram controller's slave port. It replaces the externally driven Wishbone pins on the top level.
- The host sets a 32-bit address, write data and control through byte-wide uart2bus register writes.
- The bridge then runs exactly one Wishbone transfer to the sdram controller and latches the read data and status. The host reads these back over UART.

Parameters:
- TIMEOUT, 1024: cycles in REQ+WAIT_ACK before the transfer is aborted with an error.
- TO_W, 10: width of the timeout counter. Must satisfy 2^TO_W >= TIMEOUT.

Ports:
- clk_i  in  1  system clock (clk50_dup domain)
- rst_i  in  1  synchronous reset, active-high
- int_address  in  16  uart2bus register address
- int_wr_data  in  8  uart2bus write data
- int_write  in  1  uart2bus write strobe
- int_read  in  1  uart2bus read strobe
- int_req  in  1  uart2bus bus request
- int_gnt  out  1  bus grant to uart2bus
- int_rd_data  out  8  register read data to uart2bus
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_we_o  out  1  Wishbone write enable
- wb_sel_o  out  4  Wishbone byte select
- wb_addr_o  out  32  Wishbone address
- wb_data_o  out  32  Wishbone write data
- wb_data_i  in  32  Wishbone read data
- wb_stall_i  in  1  Wishbone stall
- wb_ack_i  in  1  Wishbone acknowledge

Behaviour:
- Reset is synchronous and active-high. On reset all outputs are 0, all registers are 0 and the FSM is in IDLE.
- Grant: int_gnt is int_req registered (1-cycle latency). It drops one cycle after int_req drops.
- Register map (int_address[15:4] must be 0; other addresses read 0x00 and ignore writes). All multi-byte registers are little-endian, byte n at offset +n.
  - 0x0-0x3: ADDR, read/write.
  - 0x4-0x7: WDATA, read/write.
  - 0x8: CTRL. Writing it starts a transfer. bit1 = we, bit2 = auto-increment, bits[7:4] = sel. Reads return the last CTRL value written.
  - 0x9: STATUS, read-only. bit0 busy, bit1 done, bit2 timeout, bit3 overrun.
  - 0xC-0xF: RDATA, read-only.
- Register writes take effect on the clock edge where int_write=1.
- Register reads: int_rd_data is registered and valid the cycle after int_read=1. It holds its value until the next read.
- Reading STATUS returns the current value, then clears done, timeout and overrun on the same edge. busy is not cleared by a read.
- Writing ADDR or WDATA while busy=1 is ignored and sets overrun.
- FSM states: IDLE, REQ, WAIT_ACK.
  - IDLE: a CTRL write loads we/sel/auto-inc, clears done and timeout, sets busy, clears the timeout counter and moves to REQ. cyc=stb=1 from the next cycle.
  - REQ: cyc=1, stb=1, and wb_addr_o/wb_data_o/wb_we_o/wb_sel_o are held stable.
    - Slave accepts on an edge with stall_i=0. If ack_i is also 1 on that edge, go to completion; otherwise go to WAIT_ACK with stb=0 and cyc=1.
  - WAIT_ACK: cyc=1, stb=0. On ack_i=1, go to completion.
  - Completion: return to IDLE, busy=0, done=1, cyc=0.
    - For reads (we=0), RDATA captures wb_data_i on the ack edge. RDATA is unchanged on writes.
    - If auto-increment is set, ADDR += 4 modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
- Timeout: the counter increments every cycle in REQ/WAIT_ACK. When it reaches TIMEOUT-1 with no completion: cyc=stb=0, go to IDLE, busy=0, timeout=1, done=0, RDATA and ADDR unchanged. If ack_i and timeout coincide on the same edge, ack wins.
- wb_ack_i while in IDLE is ignored.
- A CTRL write while busy=1 is ignored (no restart) and sets overrun.
- wb_we_o and wb_sel_o are driven only from the latched CTRL value.
- rst_i asserted mid-transfer: cyc/stb are 0 from the following cycle, all registers are 0, and no completion is recorded.

Test Plan:
- Reset then read every register -> all 0x00; int_gnt=0; cyc=stb=0.
- Write ADDR=0x00000100, WDATA=0xDEADBEEF, CTRL=0xF2; slave stalls 3 cycles, acks 2 cycles after accept -> one stb accept, wb_addr_o=0x100, data=0xDEADBEEF, we=1, sel=0xF. STATUS reads 0x02, then 0x00 on second read.
- Read with ADDR=0x100, CTRL=0xF4, slave returns 0x12345678 with ack on accept edge -> RDATA bytes 0x78,0x56,0x34,0x12; ADDR reads back 0x104.
- ADDR=0xFFFFFFFC, auto-increment write -> ADDR=0x00000000 after done.
- Slave never acks -> cyc drops after exactly TIMEOUT cycles; STATUS=0x04; a second CTRL write issued mid-transfer sets overrun (STATUS bit3).
- Assert rst_i during WAIT_ACK -> cyc=0 next cycle; a late ack is ignored; STATUS=0x00.
